hub75_row_driver: RTL

Consumes one double-buffered line (64 columns × 48-bit pixel pairs) from the line RAM that the pixel generator fills, and drives the HUB-75 panel pins for one row pair. Output is 8 bit-planes with binary-coded modulation. The block sits between the line RAM read port and the panel connector. The frame sequencer starts it once per row and waits on `is_idle` before reusing the bank.

---
 rtl/hub75_pkg.sv | 40 ++++
 rtl/hub75_row_driver_if.sv | 29 ++
 rtl/bcm_display_timer.sv | 27 ++
 rtl/hub75_row_driver.sv | 124 ++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared HUB-75 line-word layout and row driver state encoding.
// The pixel generator imports the same field offsets.
package hub75_pkg;
  localparam int kPanelWidth = 64;
  localparam int kPlaneCount = 8;
  localparam int kPlaneW = 3;
  localparam int kColW = $clog2(kPanelWidth);
  localparam int kAddrW = kColW + 1;
  localparam int kWordW = 48;

  localparam int kRTop = 40;
  localparam int kGTop = 32;
  localparam int kBTop = 24;
  localparam int kRBot = 16;
  localparam int kGBot = 8;
  localparam int kBBot = 0;

  typedef enum logic [2:0] {
    kWait,
    kPrefetch,
    kShift,
    kLatch,
    kDisplay
  } state_e;

  // Returns {r1,g1,b1,r2,g2,b2} for one bit-plane of a line word.
  function automatic logic [5:0] plane_bits(
    input logic [kWordW-1:0] w,
    input logic [kPlaneW-1:0] p
  );
    logic [7:0] rt, gt, bt, rb, gb, bb;
    rt = w[kRTop +: 8];
    gt = w[kGTop +: 8];
    bt = w[kBTop +: 8];
    rb = w[kRBot +: 8];
    gb = w[kGBot +: 8];
    bb = w[kBBot +: 8];
    return {rt[p], gt[p], bt[p], rb[p], gb[p], bb[p]};
  endfunction
endpackage

// File: rtl/hub75_row_driver_if.sv
// hub75_row_driver_if: line-RAM read port plus HUB-75 panel pins.
// master is the row driver; slave is the RAM/connector side.
interface hub75_row_driver_if;
  import hub75_pkg::*;

  logic [kAddrW-1:0] read_address;
  logic [kWordW-1:0] read_data;
  logic r1, g1, b1, r2, g2, b2;
  logic panel_clock;
  logic latch;
  logic output_enable_n;
  logic [4:0] row_select;

  modport master (
    output read_address,
    input  read_data,
    output r1, g1, b1, r2, g2, b2,
    output panel_clock, latch,
    output output_enable_n, row_select
  );

  modport slave (
    input  read_address,
    output read_data,
    input  r1, g1, b1, r2, g2, b2,
    input  panel_clock, latch,
    input  output_enable_n, row_select
  );
endinterface

// File: rtl/bcm_display_timer.sv
// bcm_display_timer: loads display_unit << plane and counts down.
// done_o is high on the final display cycle.
module bcm_display_timer
  import hub75_pkg::*;
#(
  parameter int display_unit = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic [kPlaneW-1:0] plane_i,
  output logic               done_o
);
  logic [15:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= (16'(display_unit) << plane_i) - 16'd1;
    end else if (count_q != '0) begin
      count_q <= count_q - 16'd1;
    end
  end

  assign done_o = (count_q == '0);
endmodule

// File: rtl/hub75_row_driver.sv
// hub75_row_driver: shifts one line-RAM row out as 8 BCM bit-planes
// and drives the HUB-75 shift/latch/OE pins for that row pair.
module hub75_row_driver
  import hub75_pkg::*;
#(
  parameter int panel_width  = kPanelWidth,
  parameter int plane_count  = kPlaneCount,
  parameter int display_unit = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] y,
  input  logic       bank,
  output logic       is_idle,
  hub75_row_driver_if.master bus
);
  localparam int XW = $clog2(panel_width);
  localparam logic [XW-1:0] kXLast = XW'(panel_width - 1);
  localparam logic [kPlaneW-1:0] kPlaneTop = kPlaneW'(plane_count - 1);

  state_e              state_q;
  logic [XW-1:0]       x_q, x_d, addr_x;
  logic                half_q;
  logic [kPlaneW-1:0]  plane_q;
  logic [4:0]          y_q, row_q;
  logic                bank_q;
  logic [5:0]          rgb_q;
  logic                pclk_q, lat_q, oe_n_q;
  logic                done;

  assign x_d = x_q + XW'(1);

  // Half 1 fetches the next column so it lands for the next half 0.
  always_comb begin
    addr_x = '0;
    if (state_q == kShift) begin
      addr_x = half_q ? x_d : x_q;
    end
  end

  assign bus.read_address = {bank_q, addr_x};
  assign {bus.r1, bus.g1, bus.b1} = rgb_q[5:3];
  assign {bus.r2, bus.g2, bus.b2} = rgb_q[2:0];
  assign bus.panel_clock = pclk_q;
  assign bus.latch = lat_q;
  assign bus.output_enable_n = oe_n_q;
  assign bus.row_select = row_q;
  assign is_idle = (state_q == kWait);

  bcm_display_timer #(
    .display_unit(display_unit)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .load_i (state_q == kLatch),
    .plane_i(plane_q),
    .done_o (done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= kWait;
      x_q     <= '0;
      half_q  <= 1'b0;
      plane_q <= '0;
      y_q     <= '0;
      bank_q  <= 1'b0;
      rgb_q   <= '0;
      pclk_q  <= 1'b0;
      lat_q   <= 1'b0;
      oe_n_q  <= 1'b1;
      row_q   <= '0;
    end else begin
      lat_q  <= 1'b0;
      oe_n_q <= 1'b1;
      unique case (state_q)
        kWait: begin
          if (start) begin
            y_q     <= y;
            bank_q  <= bank;
            plane_q <= kPlaneTop;
            state_q <= kPrefetch;
          end
        end
        kPrefetch: begin
          x_q     <= '0;
          half_q  <= 1'b0;
          state_q <= kShift;
        end
        kShift: begin
          if (!half_q) begin
            rgb_q  <= plane_bits(bus.read_data, plane_q);
            pclk_q <= 1'b0;
            half_q <= 1'b1;
          end else begin
            pclk_q <= 1'b1;
            half_q <= 1'b0;
            x_q    <= x_d;
            if (x_q == kXLast) state_q <= kLatch;
          end
        end
        kLatch: begin
          lat_q   <= 1'b1;
          pclk_q  <= 1'b0;
          row_q   <= y_q;
          state_q <= kDisplay;
        end
        kDisplay: begin
          oe_n_q <= 1'b0;
          if (done) begin
            if (plane_q == '0) begin
              state_q <= kWait;
            end else begin
              plane_q <= plane_q - kPlaneW'(1);
              state_q <= kPrefetch;
            end
          end
        end
        default: state_q <= kWait;
      endcase
    end
  end
endmodule
